// File: rtl/akarin_lsu.sv
// akarin_lsu: load/store unit driving a req/gnt/rvalid data bus for the akarin_riscv core.
// Optional feature macro: AKARIN_LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of force-aligning).
module akarin_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              ex_we_i,
    input  logic [1:0]        ex_size_i,
    input  logic              ex_unsigned_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [31:0]       ex_wdata_i,
    input  logic [4:0]        ex_rd_i,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [3:0]        dbus_be_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic              dbus_gnt_i,
    input  logic              dbus_rvalid_i,
    input  logic [DATA_W-1:0] dbus_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_rf_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              wb_err_o,
    output logic              stall_o
);

`ifdef AKARIN_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_rf_we_q, wb_rf_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              wb_err_q, wb_err_d;

    logic              ex_misaligned;
    logic [ADDR_W-1:0] ex_addr_aligned;
    logic [3:0]        be;
    logic [31:0]       wdata_lanes;
    logic [31:0]       rdata_shifted;
    logic [31:0]       load_ext;
    logic              in_req;

    // Misalignment and natural alignment of the incoming effective address.
    always_comb begin
        ex_misaligned   = 1'b0;
        ex_addr_aligned = ex_addr_i;
        unique case (ex_size_i)
            2'b00: ;
            2'b01: begin
                ex_misaligned   = ex_addr_i[0];
                ex_addr_aligned = {ex_addr_i[ADDR_W-1:1], 1'b0};
            end
            default: begin
                ex_misaligned   = (ex_addr_i[1:0] != 2'b00);
                ex_addr_aligned = {ex_addr_i[ADDR_W-1:2], 2'b00};
            end
        endcase
    end

    // Byte enables, lane-replicated store data and load extraction from the captured request.
    always_comb begin
        be            = 4'b1111;
        wdata_lanes   = wdata_q;
        rdata_shifted = dbus_rdata_i >> {addr_q[1:0], 3'b000};
        load_ext      = rdata_shifted;
        unique case (size_q)
            2'b00: begin
                be          = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
                load_ext    = uns_q ? {24'h0, rdata_shifted[7:0]}
                                    : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            end
            2'b01: begin
                be          = 4'b0011 << {addr_q[1], 1'b0};
                wdata_lanes = {2{wdata_q[15:0]}};
                load_ext    = uns_q ? {16'h0, rdata_shifted[15:0]}
                                    : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            end
            default: ;
        endcase
    end

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wb_rf_we_d = wb_rf_we_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_err_d   = wb_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (ex_valid_i) begin
                    we_d    = ex_we_i;
                    size_d  = ex_size_i;
                    uns_d   = ex_unsigned_i;
                    addr_d  = ex_addr_aligned;
                    wdata_d = ex_wdata_i;
                    rd_d    = ex_rd_i;
                    if (TRAP_EN && ex_misaligned) begin
                        state_d    = S_RESP;
                        wb_rf_we_d = 1'b0;
                        wb_rd_d    = ex_rd_i;
                        wb_data_d  = 32'h0;
                        wb_err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dbus_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dbus_rvalid_i) begin
                    state_d    = S_RESP;
                    wb_rf_we_d = ~we_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = we_q ? 32'h0 : load_ext;
                    wb_err_d   = 1'b0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'h0;
            wb_rf_we_q <= 1'b0;
            wb_rd_q    <= 5'h0;
            wb_data_q  <= 32'h0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_rf_we_q <= wb_rf_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // Bus fields are gated by the request so they read as zero outside REQ.
    assign in_req       = (state_q == S_REQ);
    assign dbus_req_o   = in_req;
    assign dbus_we_o    = in_req & we_q;
    assign dbus_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dbus_be_o    = in_req ? be : 4'h0;
    assign dbus_wdata_o = in_req ? wdata_lanes : '0;

    assign ex_ready_o = (state_q == S_IDLE);
    assign stall_o    = (state_q != S_IDLE);
    assign wb_valid_o = (state_q == S_RESP);
    assign wb_rf_we_o = wb_rf_we_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign wb_err_o   = wb_err_q;

endmodule

// File: tb/tb_akarin_lsu.sv
// Self-checking bench for akarin_lsu: directed scenarios plus randomized accesses against a byte-level model.
// Honours AKARIN_LSU_MISALIGN_TRAP_EN in the same way as the design.
module tb_akarin_lsu;

`ifdef AKARIN_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_we_i, ex_unsigned_i;
    logic [1:0]  ex_size_i;
    logic [31:0] ex_addr_i, ex_wdata_i;
    logic [4:0]  ex_rd_i;
    logic        ex_ready_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i, dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        wb_valid_o, wb_rf_we_o, wb_err_o, stall_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    akarin_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_we_i(ex_we_i),
        .ex_size_i(ex_size_i), .ex_unsigned_i(ex_unsigned_i), .ex_addr_i(ex_addr_i),
        .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rf_we_o(wb_rf_we_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_err_o(wb_err_o), .stall_o(stall_o)
    );

    // One complete access, driven and sampled on negedges, checked cycle by cycle against the model.
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                             input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
        int          nbytes, lane;
        logic        mis, trapped;
        logic [31:0] eaddr, wd_e, ld_e, mask, sh;
        logic [3:0]  be_e;
        nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis     = (addr % nbytes) != 0;
        trapped = mis && TRAP;
        eaddr   = addr - (addr % nbytes);
        lane    = int'(eaddr % 4);
        be_e    = 4'(((1 << nbytes) - 1) << lane);
        wd_e    = (nbytes == 1) ? wdata[7:0] * 32'h01010101 :
                  (nbytes == 2) ? wdata[15:0] * 32'h00010001 : wdata;
        mask    = (nbytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nbytes)) - 32'h1;
        sh      = (rdata >> (8 * lane)) & mask;
        if (!uns && nbytes < 4 && sh[8 * nbytes - 1]) sh = sh | ~mask;
        ld_e    = (we || trapped) ? 32'h0 : sh;

        checks++;
        if (ex_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b expected 1", ex_ready_o);
        end
        ex_valid_i = 1'b1; ex_we_i = we; ex_size_i = size; ex_unsigned_i = uns;
        ex_addr_i = addr; ex_wdata_i = wdata; ex_rd_i = rd;
        @(negedge clk);
        ex_valid_i = 1'b0; ex_addr_i = $urandom; ex_wdata_i = $urandom;

        if (!trapped) begin
            for (int k = 0; k <= gnt_dly; k++) begin
                checks++;
                if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, ex_ready_o, stall_o, wb_valid_o}
                    !== {1'b1, we, eaddr & 32'hFFFF_FFFC, be_e, wd_e, 1'b0, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL req_phase[%0d]: got req=%b we=%b addr=%h be=%b wdata=%h rdy=%b stall=%b wbv=%b expected req=1 we=%b addr=%h be=%b wdata=%h rdy=0 stall=1 wbv=0",
                             k, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, ex_ready_o, stall_o,
                             wb_valid_o, we, eaddr & 32'hFFFF_FFFC, be_e, wd_e);
                end
                dbus_gnt_i    = (k == gnt_dly);
                dbus_rvalid_i = (k != gnt_dly) ? 1'($urandom) : 1'b0;
                @(negedge clk);
            end
            dbus_gnt_i = 1'b0;
            for (int k = 0; k <= rv_dly; k++) begin
                checks++;
                if ({dbus_req_o, wb_valid_o, stall_o} !== 3'b001) begin
                    errors++;
                    $display("FAIL wait_phase[%0d]: got req=%b wbv=%b stall=%b expected 0 0 1",
                             k, dbus_req_o, wb_valid_o, stall_o);
                end
                dbus_rvalid_i = (k == rv_dly);
                dbus_rdata_i  = (k == rv_dly) ? rdata : $urandom;
                dbus_gnt_i    = (k != rv_dly) ? 1'($urandom) : 1'b0;
                @(negedge clk);
            end
            dbus_rvalid_i = 1'b0; dbus_gnt_i = 1'b0; dbus_rdata_i = $urandom;
        end

        checks++;
        if ({wb_valid_o, wb_rf_we_o, wb_err_o, wb_rd_o, wb_data_o, dbus_req_o, stall_o}
            !== {1'b1, ~we & ~trapped, trapped, rd, ld_e, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wb_pulse: got v=%b we=%b err=%b rd=%0d data=%h req=%b stall=%b expected v=1 we=%b err=%b rd=%0d data=%h req=0 stall=1",
                     wb_valid_o, wb_rf_we_o, wb_err_o, wb_rd_o, wb_data_o, dbus_req_o, stall_o,
                     ~we & ~trapped, trapped, rd, ld_e);
        end
        @(negedge clk);
        checks++;
        if ({wb_valid_o, ex_ready_o, stall_o, wb_data_o, wb_rd_o} !== {1'b0, 1'b1, 1'b0, ld_e, rd}) begin
            errors++;
            $display("FAIL after_wb: got v=%b rdy=%b stall=%b data=%h rd=%0d expected v=0 rdy=1 stall=0 data=%h rd=%0d",
                     wb_valid_o, ex_ready_o, stall_o, wb_data_o, wb_rd_o, ld_e, rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_valid_i = 1'b0; ex_we_i = 1'b0; ex_size_i = 2'b00; ex_unsigned_i = 1'b0;
        ex_addr_i = 32'h0; ex_wdata_i = 32'h0; ex_rd_i = 5'h0;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
        #12;
        checks++;
        if ({ex_ready_o, stall_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
             wb_valid_o, wb_rf_we_o, wb_rd_o, wb_data_o, wb_err_o}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b stall=%b req=%b we=%b addr=%h be=%b wd=%h wbv=%b rfwe=%b rd=%0d data=%h err=%b expected rdy=1 and all else 0",
                     ex_ready_o, stall_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
                     wb_valid_o, wb_rf_we_o, wb_rd_o, wb_data_o, wb_err_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_word();
        do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0, 0);
        checks++;
        if (wb_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_data: got %h expected deadbeef", wb_data_o);
        end
    endtask

    task automatic test_lb_lbu();
        do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd3, 32'h80FF1234, 0, 1);
        checks++;
        if (wb_data_o !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_data: got %h expected ffffff80", wb_data_o);
        end
        do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd4, 32'h80FF1234, 1, 0);
        checks++;
        if (wb_data_o !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_data: got %h expected 00000080", wb_data_o);
        end
    endtask

    task automatic test_store_half_wait();
        do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 5'd9, 32'h12345678, 3, 0);
        checks++;
        if ({wb_rf_we_o, wb_data_o} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL sh_wb: got rfwe=%b data=%h expected 0 00000000", wb_rf_we_o, wb_data_o);
        end
    endtask

    task automatic test_misalign();
        do_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd11, 32'hCAFEF00D, 0, 0);
        checks++;
        if (wb_err_o !== TRAP) begin
            errors++;
            $display("FAIL misalign_err: got %b expected %b", wb_err_o, TRAP);
        end
        do_access(1'b0, 2'b01, 1'b1, 32'h3FF, 32'h0, 5'd12, 32'h8765_4321, 1, 1);
        do_access(1'b1, 2'b11, 1'b0, 32'h402, 32'h1122_3344, 5'd13, 32'h0, 0, 2);
    endtask

    task automatic test_reset_mid();
        // Reset while the request is presented on the bus.
        ex_valid_i = 1'b1; ex_we_i = 1'b0; ex_size_i = 2'b10; ex_unsigned_i = 1'b0;
        ex_addr_i = 32'h300; ex_rd_i = 5'd5;
        @(negedge clk);
        ex_valid_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({dbus_req_o, ex_ready_o, stall_o, wb_valid_o} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_in_req: got req=%b rdy=%b stall=%b wbv=%b expected 0 1 0 0",
                     dbus_req_o, ex_ready_o, stall_o, wb_valid_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset while waiting for the response, followed by a stray rvalid.
        ex_valid_i = 1'b1; ex_addr_i = 32'h304;
        @(negedge clk);
        ex_valid_i = 1'b0; dbus_gnt_i = 1'b1;
        @(negedge clk);
        dbus_gnt_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({dbus_req_o, ex_ready_o, stall_o, wb_valid_o} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_in_wait: got req=%b rdy=%b stall=%b wbv=%b expected 0 1 0 0",
                     dbus_req_o, ex_ready_o, stall_o, wb_valid_o);
        end
        @(negedge clk);
        rst = 1'b1;
        dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        dbus_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({wb_valid_o, dbus_req_o, ex_ready_o} !== 3'b001) begin
                errors++;
                $display("FAIL late_rvalid[%0d]: got wbv=%b req=%b rdy=%b expected 0 0 1",
                         k, wb_valid_o, dbus_req_o, ex_ready_o);
            end
            @(negedge clk);
        end
        do_access(1'b0, 2'b01, 1'b0, 32'h306, 32'h0, 5'd6, 32'h8001_7FFF, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
                      $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_lb_lbu();
        test_store_half_wait();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
